// File: rtl/alu_top_v3.sv
// Switch/button-loaded ALU: synchronised single-shot button loads, registered result and status flags.
// Supports chaining the previous result into A and flags opcodes that are not in the decode table.
module alu_top_v3 #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_BTN  = 4,
  parameter int NB_SW   = 8
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_DATA-1:0] o_led,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err
);

  localparam int NB_SH = $clog2(NB_DATA);
  localparam int MSB   = NB_DATA - 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state_q, state_d;
  logic [NB_BTN-1:0]   sync1, sync2, prev, pulse;
  logic [2:0]          settle;
  logic [NB_DATA-1:0]  a_q, b_q;
  logic [NB_OP-1:0]    op_q;
  logic                load;

  logic [NB_DATA:0]    sum, diff;
  logic [NB_SH-1:0]    shamt;
  logic [NB_DATA-1:0]  res;
  logic                res_carry, res_ovf, res_err;

  // Edges are ignored until prev holds a real sample, so a button held across reset release never pulses.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      settle <= '0;
    end else begin
      sync1  <= i_btn;
      sync2  <= sync1;
      prev   <= sync2;
      settle <= {settle[1:0], 1'b1};
    end
  end

  assign pulse = sync2 & ~prev & {NB_BTN{settle[2]}};
  assign load  = |pulse[3:0];

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (pulse[3])      a_q <= o_led;
      else if (pulse[0]) a_q <= i_sw[NB_DATA-1:0];
      if (pulse[1])      b_q <= i_sw[NB_DATA-1:0];
      if (pulse[2])      op_q <= i_sw[NB_OP-1:0];
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load)                 state_d = EXEC;
    else if (state_q == EXEC) state_d = DONE;
  end

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = {1'b0, a_q} - {1'b0, b_q};
  assign shamt = b_q[NB_SH-1:0];

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (op_q)
      NB_OP'(6'b100000): begin
        res       = sum[NB_DATA-1:0];
        res_carry = sum[NB_DATA];
        res_ovf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      NB_OP'(6'b100010): begin
        res       = diff[NB_DATA-1:0];
        res_carry = diff[NB_DATA];
        res_ovf   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      NB_OP'(6'b100100): res = a_q & b_q;
      NB_OP'(6'b100101): res = a_q | b_q;
      NB_OP'(6'b100110): res = a_q ^ b_q;
      NB_OP'(6'b100111): res = ~(a_q | b_q);
      NB_OP'(6'b000010): res = a_q >> shamt;
      NB_OP'(6'b000011): res = $unsigned($signed(a_q) >>> shamt);
      default:           res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_led   <= '0;
      o_zero  <= 1'b0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
    end else if (state_q == EXEC) begin
      o_led   <= res;
      o_zero  <= (res == '0);
      o_carry <= res_carry;
      o_ovf   <= res_ovf;
      o_err   <= res_err;
    end
  end

  assign o_valid = (state_q == DONE);

endmodule

// File: tb/tb_alu_top_v3.sv
// Directed and randomised checks of alu_top_v3 against an integer-arithmetic reference model.
module tb_alu_top_v3;

  logic       clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_sw;
  logic [3:0] i_btn;
  logic [7:0] o_led;
  logic       o_valid, o_zero, o_carry, o_ovf, o_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] a_m, b_m, led_m;
  logic [5:0] op_m;
  logic       c_m, v_m, e_m, z_m;

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

  alu_top_v3 #(.NB_DATA(8), .NB_OP(6), .NB_BTN(4), .NB_SW(8)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_valid (o_valid),
    .o_zero  (o_zero),
    .o_carry (o_carry),
    .o_ovf   (o_ovf),
    .o_err   (o_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_m = '0; b_m = '0; op_m = '0; led_m = '0;
    c_m = 1'b0; v_m = 1'b0; e_m = 1'b0; z_m = 1'b0;
  endtask

  // Result from plain signed/unsigned integer arithmetic on the operand values.
  task automatic model_exec();
    int a, b, sa, sb, r, sr;
    a = int'(a_m); b = int'(b_m);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = 0; c_m = 1'b0; v_m = 1'b0; e_m = 1'b0;
    case (op_m)
      6'h20: begin r = a + b; c_m = (r > 255); sr = sa + sb; v_m = (sr > 127) || (sr < -128); end
      6'h22: begin r = a - b; c_m = (a < b);   sr = sa - sb; v_m = (sr > 127) || (sr < -128); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> (b % 8);
      6'h03: r = sa >>> (b % 8);
      default: begin r = 0; e_m = 1'b1; end
    endcase
    led_m = 8'(r & 255);
    z_m = (led_m == 8'h00);
  endtask

  task automatic model_load(input logic [3:0] m, input logic [7:0] sw);
    if (m[3])      a_m = led_m;
    else if (m[0]) a_m = sw;
    if (m[1])      b_m = sw;
    if (m[2])      op_m = sw[5:0];
    model_exec();
  endtask

  task automatic expect_all(input string tag);
    chk({tag, "_led"},   32'(o_led),   32'(led_m));
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_zero"},  32'(o_zero),  32'(z_m));
    chk({tag, "_carry"}, 32'(o_carry), 32'(c_m));
    chk({tag, "_ovf"},   32'(o_ovf),   32'(v_m));
    chk({tag, "_err"},   32'(o_err),   32'(e_m));
  endtask

  // Button driven before E0: busy after the load edge E2, result visible after E3.
  task automatic press(input logic [3:0] m, input logic [7:0] sw, input string tag);
    @(negedge clock);
    i_sw = sw; i_btn = m;
    repeat (3) @(posedge clock);
    #1 chk({tag, "_busy"}, 32'(o_valid), 32'd0);
    model_load(m, sw);
    @(posedge clock);
    #1 expect_all(tag);
    @(negedge clock);
    i_btn = '0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int lows;
    logic [3:0] m;
    logic [7:0] sw;

    i_reset = 1'b0; i_sw = '0; i_btn = '0;
    model_reset();

    repeat (5) begin
      @(negedge clock);
      i_sw = 8'($urandom); i_btn = 4'($urandom);
      #1 chk("rst_outs", 32'({o_led, o_valid, o_zero, o_carry, o_ovf, o_err}), 32'd0);
    end

    @(negedge clock);
    i_btn = 4'b0001; i_sw = 8'h5A; i_reset = 1'b1;
    repeat (8) @(negedge clock);
    chk("rst_held_valid", 32'(o_valid), 32'd0);
    chk("rst_held_led",   32'(o_led),   32'd0);
    i_btn = '0;
    repeat (4) @(negedge clock);

    press(4'b0001, 8'h7F, "ldA_7f");
    press(4'b0010, 8'h01, "ldB_01");
    press(4'b0100, 8'h20, "add");
    chk("add_led_const", 32'(o_led), 32'h80);
    chk("add_ovf_const", 32'(o_ovf), 32'd1);

    press(4'b0001, 8'h00, "ldA_00");
    press(4'b0100, 8'h22, "sub_wrap");
    chk("sub_wrap_const", 32'({o_led, o_carry, o_ovf}), 32'({8'hFF, 1'b1, 1'b0}));
    press(4'b0001, 8'h80, "sub_ovf");
    chk("sub_ovf_const", 32'({o_led, o_carry, o_ovf}), 32'({8'h7F, 1'b0, 1'b1}));

    // Held button: one load of 0x11 despite the switch change and long hold.
    @(negedge clock);
    i_sw = 8'h11; i_btn = 4'b0001;
    repeat (3) @(posedge clock);
    #1 chk("held_busy", 32'(o_valid), 32'd0);
    model_load(4'b0001, 8'h11);
    @(posedge clock);
    #1 expect_all("held");
    lows = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c == 1) i_sw = 8'h22;
      if (!o_valid) lows++;
    end
    chk("held_single_exec", 32'(lows), 32'd0);
    chk("held_led_const", 32'(o_led), 32'h10);
    i_btn = '0;
    repeat (4) @(negedge clock);

    press(4'b0001, 8'h05, "ldA_05");
    press(4'b0010, 8'h03, "ldB_03");
    press(4'b0100, 8'h20, "add_58");
    chk("add_58_const", 32'(o_led), 32'h08);
    press(4'b1000, 8'h00, "chain");
    chk("chain_const", 32'(o_led), 32'h0B);
    press(4'b1001, 8'h44, "chain_wins");
    chk("chain_wins_const", 32'(o_led), 32'h0E);

    press(4'b0100, 8'h3F, "invalid");
    chk("invalid_const", 32'({o_led, o_err, o_zero}), 32'({8'h00, 1'b1, 1'b1}));
    press(4'b0001, 8'h80, "ldA_80");
    press(4'b0010, 8'h09, "ldB_09");
    press(4'b0100, 8'h03, "sra");
    chk("sra_const", 32'({o_led, o_err}), 32'({8'hC0, 1'b0}));

    // Asynchronous reset while the B load is executing.
    @(negedge clock);
    i_sw = 8'h01; i_btn = 4'b0010;
    repeat (3) @(posedge clock);
    #1 i_reset = 1'b0; i_btn = '0;
    #1 chk("abort_outs", 32'({o_led, o_valid, o_zero, o_carry, o_ovf, o_err}), 32'd0);
    model_reset();
    @(negedge clock);
    i_reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("abort_idle", 32'(o_valid), 32'd0);
    press(4'b0010, 8'h05, "post_abort");

    for (int i = 0; i < 40; i++) begin
      m  = 4'($urandom_range(1, 15));
      sw = 8'($urandom);
      if (m[2] && ($urandom_range(0, 3) != 0)) sw[5:0] = valid_ops[$urandom_range(0, 7)];
      press(m, sw, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
